fp32_serial_ctrl: RTL and testbench
===================================

# fp32_serial_ctrl

Transaction controller for the serial-I/O fp32 adder. It receives operands A and B bit-serially on one pin and steers them into the operand shift registers via shift enables. It then launches the adder, captures the 32-bit sum and shifts it out MSB-first on one pin. It sits between the chip-level serial pins and the operand-register/adder datapath.

## Interface
- WORD_W, 32: operand/result width; the counter is sized to clog2(WORD_W).
- TIMEOUT, 64: maximum cycles in WAIT for add_done before aborting.

- clk  in  1  clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high; forces IDLE and all outputs low.
- start  in  1  one-cycle request to begin a transaction; sampled only in IDLE.
- sdi  in  1  serial operand data, MSB first: A[31..0] then B[31..0].
- lda  out  1  shift enable for operand-A register.
- ldb  out  1  shift enable for operand-B register.
- sin  out  1  serial bit to operand registers; combinational copy of sdi.
- add_go  out  1  one-cycle launch pulse to the adder.
- add_done  in  1  adder result valid; sampled only in WAIT.
- result  in  WORD_W  adder sum, valid while add_done is high.
- sdo  out  1  serial result, MSB first.
- sdo_valid  out  1  high while sdo carries a result bit.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at the end of a successful transaction.
- err  out  1  sticky timeout flag; cleared by the next accepted start or by reset.

## Operation
- States: IDLE, LOAD_A, LOAD_B, GO, WAIT, SHIFT, DONE. Encodings live in the shared defines.
- All outputs except sin are registered and decoded from state:
  - lda = LOAD_A
  - ldb = LOAD_B
  - add_go = GO
  - sdo_valid = SHIFT
  - done = DONE
  - busy = not IDLE
- Downstream registers shift left and take sin into the LSB, so MSB-first delivery leaves A[31] in bit 31.
- IDLE: start=1 clears err and the bit counter, then moves to LOAD_A.
- LOAD_A: the counter increments each cycle. When the counter reaches WORD_W-1, it wraps to 0 and the state moves to LOAD_B.
- LOAD_B: same counting, exiting to GO.
- GO: one cycle, then WAIT. The timeout counter clears on entry to WAIT.
- WAIT:
  - add_done=1: load result into the internal output shift register and go to SHIFT.
  - After TIMEOUT cycles without add_done: set err and return to IDLE. No done pulse is issued.
- SHIFT: sdo = shift-register MSB. The register shifts left by one each cycle, filling with 0. After WORD_W cycles, go to DONE.
- DONE: one cycle, then IDLE.
- Boundary rules:
  - start outside IDLE is ignored.
  - add_done outside WAIT is ignored.
  - add_done on the same cycle as timeout expiry is treated as success.
  - sdo = 0 whenever sdo_valid = 0.
- Reset mid-transaction aborts immediately. There is no partial result. The operand registers share the same reset, so they are cleared too.

## Timing
- Reset values: lda, ldb, add_go, sdo, sdo_valid, busy, done, err, counters and shift register are all 0; state is IDLE.
- Cycle numbering: start is sampled at edge 0.
  - lda is high for cycles 1–32.
  - ldb is high for cycles 33–64.
  - add_go is high in cycle 65.
  - WAIT begins at cycle 66.
- With add_done arriving in WAIT cycle k (k ≥ 0 counted from entry):
  - SHIFT covers cycles 67+k through 98+k.
  - done is high in cycle 99+k.
  - The earliest next start is accepted at cycle 100+k.
- Timeout:
  - err rises and busy falls at cycle 66+TIMEOUT.
  - err stays high until the next accepted start, then clears on that cycle.
- sdi must be stable around each posedge on which lda or ldb is high.

## Structure
- Shared define file fp32_io_defs.vh holds:
  - state encodings (3-bit)
  - WORD_W default
  - counter width
- One sub-module: fp32_piso, a WORD_W parallel-load, serial-out shift register with load, shift and MSB output.
- The FSM, bit counter and timeout counter stay in fp32_serial_ctrl.

## Test plan
- Reset then idle: all outputs 0, and busy stays 0 for 10 cycles with start=0.
- Full transaction: sdi = 0x3F800000 then 0x40000000, add_done on the first WAIT cycle with result=0x40400000. Required: lda is high for exactly 32 cycles, then ldb for 32, add_go pulses at cycle 65, sdo emits 0x40400000 MSB-first over cycles 67–98, done pulses at cycle 99.
- Delayed add_done (k=10): SHIFT starts at cycle 77, done pulses at cycle 109, and add_go pulses exactly once.
- Timeout: add_done held at 0. Required: err=1 and busy=0 at cycle 66+TIMEOUT, no done pulse, sdo_valid never asserts. A following start clears err and the following transaction completes.
- start pulses at cycles 10, 40 and 66: all ignored, with no extra lda/ldb cycles and timing identical to the full-transaction case.
- reset asserted at cycle 50 (in LOAD_B): all outputs 0 asynchronously and state IDLE. A new start after reset yields a correct result.

Source files
------------

// File: rtl/fp32_serial_ctrl_pkg.sv
// Shared state encodings and default sizes for the serial-I/O fp32 adder controller.
package fp32_serial_ctrl_pkg;
   localparam int WORD_W_DEF  = 32;
   localparam int TIMEOUT_DEF = 64;
   localparam int CNT_W_DEF   = $clog2(WORD_W_DEF);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD_A = 3'd1,
      ST_LOAD_B = 3'd2,
      ST_GO     = 3'd3,
      ST_WAIT   = 3'd4,
      ST_SHIFT  = 3'd5,
      ST_DONE   = 3'd6
   } state_e;

   function automatic logic is_busy(input state_e s);
      return s != ST_IDLE;
   endfunction
endpackage

// File: rtl/fp32_serial_ctrl_piso.sv
// Parallel-load, serial-out shift register holding the adder sum for MSB-first delivery.
import fp32_serial_ctrl_pkg::*;

module fp32_piso #(
   parameter int WORD_W = WORD_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              shift,
   input  logic [WORD_W-1:0] din,
   output logic              msb
);
   logic [WORD_W-1:0] sr_q, sr_d;

   always_comb begin
      sr_d = sr_q;
      if (load)
         sr_d = din;
      else if (shift)
         sr_d = {sr_q[WORD_W-2:0], 1'b0};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) sr_q <= '0;
      else       sr_q <= sr_d;
   end

   assign msb = sr_q[WORD_W-1];
endmodule

// File: rtl/fp32_serial_ctrl.sv
// Transaction controller: serial operand load, adder launch with timeout, serial result shift-out.
import fp32_serial_ctrl_pkg::*;

module fp32_serial_ctrl #(
   parameter int WORD_W  = WORD_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              sdi,
   output logic              lda,
   output logic              ldb,
   output logic              sin,
   output logic              add_go,
   input  logic              add_done,
   input  logic [WORD_W-1:0] result,
   output logic              sdo,
   output logic              sdo_valid,
   output logic              busy,
   output logic              done,
   output logic              err
);
   localparam int CNT_W = $clog2(WORD_W);
   localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             err_q, err_d;
   logic             lda_q, lda_d, ldb_q, ldb_d, add_go_q, add_go_d;
   logic             sdo_valid_q, sdo_valid_d, busy_q, busy_d, done_q, done_d;
   logic             sr_load, sr_shift, sr_msb;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      tmo_d    = tmo_q;
      err_d    = err_q;
      sr_load  = 1'b0;
      sr_shift = 1'b0;
      case (state_q)
         ST_IDLE: if (start) begin
            err_d   = 1'b0;
            cnt_d   = '0;
            state_d = ST_LOAD_A;
         end
         ST_LOAD_A: if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = ST_LOAD_B;
         end else cnt_d = cnt_q + CNT_W'(1);
         ST_LOAD_B: if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = ST_GO;
         end else cnt_d = cnt_q + CNT_W'(1);
         ST_GO: begin
            tmo_d   = '0;
            state_d = ST_WAIT;
         end
         // add_done wins over an expiring timeout on the same cycle
         ST_WAIT: if (add_done) begin
            sr_load = 1'b1;
            cnt_d   = '0;
            state_d = ST_SHIFT;
         end else if (tmo_q == TMO_LAST) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
         end else tmo_d = tmo_q + TMO_W'(1);
         ST_SHIFT: begin
            sr_shift = 1'b1;
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = ST_DONE;
            end else cnt_d = cnt_q + CNT_W'(1);
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      lda_d       = (state_d == ST_LOAD_A);
      ldb_d       = (state_d == ST_LOAD_B);
      add_go_d    = (state_d == ST_GO);
      sdo_valid_d = (state_d == ST_SHIFT);
      done_d      = (state_d == ST_DONE);
      busy_d      = is_busy(state_d);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         tmo_q       <= '0;
         err_q       <= 1'b0;
         lda_q       <= 1'b0;
         ldb_q       <= 1'b0;
         add_go_q    <= 1'b0;
         sdo_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         tmo_q       <= tmo_d;
         err_q       <= err_d;
         lda_q       <= lda_d;
         ldb_q       <= ldb_d;
         add_go_q    <= add_go_d;
         sdo_valid_q <= sdo_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   fp32_piso #(.WORD_W(WORD_W)) u_piso (
      .clk   (clk),
      .reset (reset),
      .load  (sr_load),
      .shift (sr_shift),
      .din   (result),
      .msb   (sr_msb)
   );

   assign sin       = sdi;
   assign lda       = lda_q;
   assign ldb       = ldb_q;
   assign add_go    = add_go_q;
   assign sdo_valid = sdo_valid_q;
   assign sdo       = sdo_valid_q & sr_msb;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
endmodule

// File: tb/tb_fp32_serial_ctrl.sv
// Bench for fp32_serial_ctrl: transaction-level timing model plus directed and random transactions.
module tb_fp32_serial_ctrl;
   localparam int WORD_W  = 32;
   localparam int TIMEOUT = 64;

   logic clk = 1'b0;
   logic reset, start, sdi, lda, ldb, sin, add_go, add_done, sdo, sdo_valid, busy, done, err;
   logic [WORD_W-1:0] result;

   fp32_serial_ctrl #(.WORD_W(WORD_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .start(start), .sdi(sdi), .lda(lda), .ldb(ldb), .sin(sin),
      .add_go(add_go), .add_done(add_done), .result(result), .sdo(sdo), .sdo_valid(sdo_valid),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          act;
      int          s;
      int          kd;
      logic [31:0] a, b, r;
   } txn_t;

   typedef struct packed {
      logic lda, ldb, go, sv, sdo, busy, done, err;
   } outs_t;

   txn_t tx, plan;
   bit   pend, rand_ad;
   int   ecnt, vectors, miscompares;
   int   xs[$];
   int   n_lda, n_ldb, n_go, n_sv, n_done, n_busy, go_rel, sv_rel, done_rel, err_rel;
   logic [31:0] a_sh, b_sh, sdo_word;
   logic prev_sv, prev_err;

   // add_done latency that actually lands inside WAIT, or -1 for a timeout
   function automatic int outcome_k(input txn_t t);
      return (t.kd >= 0 && t.kd < TIMEOUT) ? t.kd : -1;
   endfunction

   function automatic int cur_rel();
      return ecnt - tx.s + 1;
   endfunction

   function automatic outs_t model(input int rel);
      outs_t o;
      int    k;
      o = '0;
      if (!tx.act) return o;
      k = outcome_k(tx);
      o.lda = (rel >= 1 && rel <= WORD_W);
      o.ldb = (rel > WORD_W && rel <= 2*WORD_W);
      o.go  = (rel == 2*WORD_W + 1);
      if (k >= 0) begin
         o.sv = (rel >= 2*WORD_W + 3 + k && rel <= 3*WORD_W + 2 + k);
         if (o.sv) o.sdo = tx.r[WORD_W - 1 - (rel - (2*WORD_W + 3 + k))];
         o.done = (rel == 3*WORD_W + 3 + k);
         o.busy = (rel >= 1 && rel <= 3*WORD_W + 3 + k);
      end else begin
         o.busy = (rel >= 1 && rel <= 2*WORD_W + 1 + TIMEOUT);
         o.err  = (rel >= 2*WORD_W + 2 + TIMEOUT);
      end
      return o;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
      end
   endtask

   task automatic check_cycle();
      outs_t e, g;
      int    rel;
      rel = cur_rel();
      e = model(rel);
      g = {lda, ldb, add_go, sdo_valid, sdo, busy, done, err};
      vectors++;
      if (g !== e) begin
         miscompares++;
         $display("FAIL outputs edge=%0d rel=%0d {lda,ldb,go,sv,sdo,busy,done,err} got %b required %b",
                  ecnt, rel, g, e);
      end
      if (lda) n_lda++;
      if (ldb) n_ldb++;
      if (busy) n_busy++;
      if (add_go) begin n_go++; go_rel = rel; end
      if (sdo_valid && !prev_sv) sv_rel = rel;
      if (sdo_valid) begin n_sv++; sdo_word = {sdo_word[30:0], sdo}; end
      if (done) begin n_done++; done_rel = rel; end
      if (err && !prev_err) err_rel = rel;
      prev_sv  = sdo_valid;
      prev_err = err;
   endtask

   task automatic drive_inputs();
      outs_t cur;
      int    rel, k, wend;
      rel = cur_rel();
      cur = model(rel);
      sdi      = 1'($urandom % 2);
      result   = 32'($urandom);
      add_done = 1'b0;
      start    = 1'b0;
      if (tx.act) begin
         if (rel >= 1 && rel <= WORD_W) sdi = tx.a[WORD_W - rel];
         else if (rel > WORD_W && rel <= 2*WORD_W) sdi = tx.b[2*WORD_W - rel];
         k    = outcome_k(tx);
         wend = (k >= 0) ? 2*WORD_W + 2 + k : 2*WORD_W + 1 + TIMEOUT;
         if (tx.kd >= 0 && rel == 2*WORD_W + 2 + tx.kd) begin
            add_done = 1'b1;
            result   = tx.r;
         end else if (rand_ad && (rel < 2*WORD_W + 2 || rel > wend))
            add_done = ($urandom % 3 == 0);
         foreach (xs[i]) if (xs[i] == rel) start = 1'b1;
         if (rand_ad && cur.busy && ($urandom % 8 == 0)) start = 1'b1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      ecnt++;
      if (pend) begin
         tx = plan; tx.act = 1'b1; tx.s = ecnt; pend = 1'b0;
         n_lda = 0; n_ldb = 0; n_go = 0; n_sv = 0; n_done = 0;
         go_rel = -1; sv_rel = -1; done_rel = -1; err_rel = -1;
      end
      #1;
      check_cycle();
      drive_inputs();
      #1;
      vectors++;
      if (sin !== sdi) begin
         miscompares++;
         $display("FAIL sin: got %b required %b", sin, sdi);
      end
      if (lda) a_sh = {a_sh[30:0], sin};
      if (ldb) b_sh = {b_sh[30:0], sin};
   endtask

   task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r, input int kd);
      outs_t cur;
      plan.a = a; plan.b = b; plan.r = r; plan.kd = kd; plan.act = 1'b1; plan.s = 0;
      cur   = model(cur_rel());
      start = 1'b1;
      if (!cur.busy) pend = 1'b1;
      tick();
   endtask

   task automatic finish_txn();
      outs_t cur;
      for (int i = 0; i < 400; i++) begin
         cur = model(cur_rel());
         if (!cur.busy) break;
         tick();
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; sdi = 1'b0; add_done = 1'b0; result = '0;
      tx = '{act: 1'b0, s: 0, kd: 0, a: 32'h0, b: 32'h0, r: 32'h0};
      plan = tx; pend = 1'b0; rand_ad = 1'b0;
      ecnt = 0; vectors = 0; miscompares = 0;
      prev_sv = 1'b0; prev_err = 1'b0; a_sh = '0; b_sh = '0; sdo_word = '0;
      repeat (3) tick();
      reset = 1'b0;
      chk("reset_outs", 32'({lda, ldb, add_go, sdo, sdo_valid, busy, done, err}), 32'h0);
      n_busy = 0;
      repeat (10) tick();
      chk("idle_busy_cycles", n_busy, 0);

      // Reference transaction: 1.0 + 2.0 = 3.0
      launch(32'h3F800000, 32'h40000000, 32'h40400000, 0);
      finish_txn();
      chk("full_lda_cycles", n_lda, 32);
      chk("full_ldb_cycles", n_ldb, 32);
      chk("full_go_rel", go_rel, 65);
      chk("full_shift_start", sv_rel, 67);
      chk("full_shift_cycles", n_sv, 32);
      chk("full_sdo_word", sdo_word, 32'h40400000);
      chk("full_done_rel", done_rel, 99);
      chk("full_opA", a_sh, 32'h3F800000);
      chk("full_opB", b_sh, 32'h40000000);

      launch(32'h12345678, 32'h9ABCDEF0, 32'hC0FFEE11, 10);
      finish_txn();
      chk("k10_shift_start", sv_rel, 77);
      chk("k10_done_rel", done_rel, 109);
      chk("k10_go_count", n_go, 1);
      chk("k10_sdo_word", sdo_word, 32'hC0FFEE11);

      launch(32'hAAAA5555, 32'h0F0F0F0F, 32'h11111111, -1);
      finish_txn();
      chk("tmo_err", 32'(err), 1);
      chk("tmo_busy", 32'(busy), 0);
      chk("tmo_err_rel", err_rel, 66 + TIMEOUT);
      chk("tmo_done_count", n_done, 0);
      chk("tmo_sv_count", n_sv, 0);
      launch(32'h3F800000, 32'h3F800000, 32'h40000000, 3);
      chk("tmo_err_cleared", 32'(err), 0);
      finish_txn();
      chk("after_tmo_sdo_word", sdo_word, 32'h40000000);

      xs = '{10, 40, 66};
      launch(32'h3F800000, 32'h40000000, 32'h40400000, 0);
      finish_txn();
      xs.delete();
      chk("ign_lda_cycles", n_lda, 32);
      chk("ign_ldb_cycles", n_ldb, 32);
      chk("ign_go_rel", go_rel, 65);
      chk("ign_done_rel", done_rel, 99);
      chk("ign_sdo_word", sdo_word, 32'h40400000);

      launch(32'hDEADBEEF, 32'h01234567, 32'h76543210, 0);
      for (int i = 0; i < 100 && cur_rel() < 50; i++) tick();
      #2;
      reset  = 1'b1;
      tx.act = 1'b0;
      #1;
      chk("async_reset_outs", 32'({lda, ldb, add_go, sdo, sdo_valid, busy, done, err}), 32'h0);
      repeat (2) tick();
      reset = 1'b0;
      launch(32'h40400000, 32'h3F800000, 32'h40800000, 2);
      finish_txn();
      chk("post_reset_sdo_word", sdo_word, 32'h40800000);
      chk("post_reset_opA", a_sh, 32'h40400000);

      rand_ad = 1'b1;
      for (int t = 0; t < 12; t++) begin
         int          kd;
         logic [31:0] ra, rb, rr;
         case (t % 6)
            0: kd = TIMEOUT - 1;
            1: kd = TIMEOUT;
            2: kd = -1;
            default: kd = int'($urandom_range(0, 20));
         endcase
         ra = 32'($urandom); rb = 32'($urandom); rr = 32'($urandom);
         launch(ra, rb, rr, kd);
         finish_txn();
         chk("rand_opA", a_sh, ra);
         chk("rand_opB", b_sh, rb);
         if (kd >= 0 && kd < TIMEOUT) chk("rand_sdo_word", sdo_word, rr);
         else chk("rand_tmo_err", 32'(err), 1);
         repeat ($urandom_range(0, 3)) tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
